// File: rtl/crc_mem_pkg.sv
// Shared types for the crc_mem write scheduler and its error monitor.
package crc_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_SETTLE = 2'd2
  } sched_state_e;

  // Which requester (0 or 1) owns a write.
  typedef logic owner_t;

  localparam int SETTLE_W = 4;

endpackage

// File: rtl/crc_err_event_cnt.sv
// Error event monitor: rising-edge detect on err_detected while the memory is
// quiet, saturating detected/uncorrected counters, sticky alarm, owner capture.
module crc_err_event_cnt
  import crc_mem_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int ALARM_THRESH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_idle,
  input  logic             i_det,
  input  logic             i_corr,
  input  logic             i_clr,
  input  owner_t           i_last_owner,
  output owner_t           o_err_owner,
  output logic [CNT_W-1:0] o_cnt_det,
  output logic [CNT_W-1:0] o_cnt_unc,
  output logic             o_alarm
);

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(ALARM_THRESH);

  logic             r_det_prev;
  logic [CNT_W-1:0] r_cnt_det;
  logic [CNT_W-1:0] r_cnt_unc;
  logic             r_alarm;
  owner_t           r_err_owner;

  logic             w_event;
  logic             w_unc_event;
  logic [CNT_W-1:0] w_det_next;
  logic [CNT_W-1:0] w_unc_next;

  // A new event is a 0->1 on err_detected, only while no write is settling.
  assign w_event     = i_idle && i_det && !r_det_prev;
  assign w_unc_event = w_event && !i_corr;
  assign w_det_next  = (r_cnt_det == '1) ? r_cnt_det : r_cnt_det + 1'b1;
  assign w_unc_next  = (r_cnt_unc == '1) ? r_cnt_unc : r_cnt_unc + 1'b1;

  // Edge-detect history; held at 0 outside IDLE so each write re-arms it.
  always_ff @(posedge clk) begin
    if (rst)         r_det_prev <= 1'b0;
    else if (i_idle) r_det_prev <= i_det;
    else             r_det_prev <= 1'b0;
  end

  // Counters, alarm and owner capture; clear beats a coincident event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_det   <= '0;
      r_cnt_unc   <= '0;
      r_alarm     <= 1'b0;
      r_err_owner <= 1'b0;
    end else if (i_clr) begin
      r_cnt_det <= '0;
      r_cnt_unc <= '0;
      r_alarm   <= 1'b0;
    end else if (w_event) begin
      r_cnt_det   <= w_det_next;
      r_err_owner <= i_last_owner;
      if (w_unc_event) begin
        r_cnt_unc <= w_unc_next;
        if (w_unc_next >= THRESH) r_alarm <= 1'b1;
      end
    end
  end

  assign o_cnt_det   = r_cnt_det;
  assign o_cnt_unc   = r_cnt_unc;
  assign o_alarm     = r_alarm;
  assign o_err_owner = r_err_owner;

endmodule

// File: rtl/crc_mem_wr_sched.sv
// Round-robin write scheduler for one crc_mem write port. Accepts one write,
// pulses mem_wr for a cycle, then waits for the CRC check to settle.
module crc_mem_wr_sched
  import crc_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int SETTLE_CYC   = 2,
  parameter int CNT_W        = 8,
  parameter int ALARM_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  mem_wr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic                  mem_err_detected,
  input  logic                  mem_err_corrected,
  input  logic                  err_clr,
  output logic                  busy,
  output logic                  last_owner,
  output logic                  err_owner,
  output logic [CNT_W-1:0]      err_cnt_det,
  output logic [CNT_W-1:0]      err_cnt_unc,
  output logic                  alarm
);

  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYC - 1);

  sched_state_e          r_state;
  logic                  r_ptr;
  owner_t                r_last_owner;
  logic [DATA_WIDTH-1:0] r_data;
  logic [SETTLE_W-1:0]   r_settle;

  logic w_idle;
  logic w_gnt0;
  logic w_gnt1;
  logic w_acc0;
  logic w_acc1;

  // Lone requester wins; on contention the round-robin pointer decides.
  assign w_idle     = (r_state == S_IDLE);
  assign w_gnt1     = req1_valid && (!req0_valid || r_ptr);
  assign w_gnt0     = req0_valid && !w_gnt1;
  assign req0_ready = !rst && w_idle && w_gnt0;
  assign req1_ready = !rst && w_idle && w_gnt1;
  assign w_acc0     = req0_valid && req0_ready;
  assign w_acc1     = req1_valid && req1_ready;

  // Scheduler FSM: capture on handshake, one-cycle write, settle countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= 1'b0;
      r_last_owner <= 1'b0;
      r_data       <= '0;
      r_settle     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc0 || w_acc1) begin
            r_data       <= w_acc1 ? req1_data : req0_data;
            r_last_owner <= w_acc1;
            r_ptr        <= !w_acc1;
            r_state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_settle <= SETTLE_INIT;
          r_state  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_settle == '0) r_state <= S_IDLE;
          else                r_settle <= r_settle - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_wr      = (r_state == S_WRITE);
  assign mem_data_in = r_data;
  assign busy        = !w_idle;
  assign last_owner  = r_last_owner;

  crc_err_event_cnt #(
    .CNT_W        (CNT_W),
    .ALARM_THRESH (ALARM_THRESH)
  ) u_err_cnt (
    .clk          (clk),
    .rst          (rst),
    .i_idle       (w_idle),
    .i_det        (mem_err_detected),
    .i_corr       (mem_err_corrected),
    .i_clr        (err_clr),
    .i_last_owner (r_last_owner),
    .o_err_owner  (err_owner),
    .o_cnt_det    (err_cnt_det),
    .o_cnt_unc    (err_cnt_unc),
    .o_alarm      (alarm)
  );

endmodule

// File: tb/tb_crc_mem_wr_sched.sv
// Directed bench for crc_mem_wr_sched: arbitration, write timing, error
// counting, saturation, alarm/clear and mid-write reset.
module tb_crc_mem_wr_sched;

  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          mem_wr;
  logic [DW-1:0] mem_data_in;
  logic          mem_err_detected, mem_err_corrected, err_clr;
  logic          busy, last_owner, err_owner, alarm;
  logic [CW-1:0] err_cnt_det, err_cnt_unc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  crc_mem_wr_sched #(
    .DATA_WIDTH   (DW),
    .SETTLE_CYC   (2),
    .CNT_W        (CW),
    .ALARM_THRESH (2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req0_valid        (req0_valid),
    .req0_data         (req0_data),
    .req0_ready        (req0_ready),
    .req1_valid        (req1_valid),
    .req1_data         (req1_data),
    .req1_ready        (req1_ready),
    .mem_wr            (mem_wr),
    .mem_data_in       (mem_data_in),
    .mem_err_detected  (mem_err_detected),
    .mem_err_corrected (mem_err_corrected),
    .err_clr           (err_clr),
    .busy              (busy),
    .last_owner        (last_owner),
    .err_owner         (err_owner),
    .err_cnt_det       (err_cnt_det),
    .err_cnt_unc       (err_cnt_unc),
    .alarm             (alarm)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [CW-1:0] d, input logic [CW-1:0] u,
                         input logic ow, input logic al);
    chk({tag, ".det"},   32'(err_cnt_det), 32'(d));
    chk({tag, ".unc"},   32'(err_cnt_unc), 32'(u));
    chk({tag, ".owner"}, 32'(err_owner),   32'(ow));
    chk({tag, ".alarm"}, 32'(alarm),       32'(al));
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    mem_err_detected = 1'b0; mem_err_corrected = 1'b0; err_clr = 1'b0;
    tick(); tick();

    // Reset state; ready held low while rst is high.
    req0_valid = 1'b1;
    #1;
    chk("rst.ready0", 32'(req0_ready), 0);
    chk("rst.mem_wr", 32'(mem_wr), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.data", mem_data_in, 0);
    chk("rst.last_owner", 32'(last_owner), 0);
    chk_cnt("rst", 0, 0, 0, 0);
    req0_valid = 1'b0;
    rst = 1'b0;

    // 1: single requester, write timing with SETTLE_CYC=2.
    req0_valid = 1'b1; req0_data = 32'hDEADBEEF;
    #1;
    chk("t1.ready_t", 32'(req0_ready), 1);
    chk("t1.ready1_t", 32'(req1_ready), 0);
    tick();
    chk("t1.mem_wr", 32'(mem_wr), 1);
    chk("t1.data", mem_data_in, 32'hDEADBEEF);
    chk("t1.busy1", 32'(busy), 1);
    chk("t1.ready_t1", 32'(req0_ready), 0);
    tick();
    chk("t1.mem_wr_t2", 32'(mem_wr), 0);
    chk("t1.busy2", 32'(busy), 1);
    tick();
    chk("t1.busy3", 32'(busy), 1);
    chk("t1.ready_t3", 32'(req0_ready), 0);
    tick();
    chk("t1.busy4", 32'(busy), 0);
    chk("t1.ready_t4", 32'(req0_ready), 1);
    chk("t1.data_hold", mem_data_in, 32'hDEADBEEF);
    req0_valid = 1'b0;

    // 2: both valid from reset -> 0,1,0,1 every four cycles.
    rst = 1'b1; tick(); rst = 1'b0;
    req0_valid = 1'b1; req0_data = 32'hA0A0A0A0;
    req1_valid = 1'b1; req1_data = 32'hB1B1B1B1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t2.ready0[%0d]", k), 32'(req0_ready), 32'((k % 2) == 0));
      chk($sformatf("t2.ready1[%0d]", k), 32'(req1_ready), 32'((k % 2) == 1));
      tick();
      chk($sformatf("t2.mem_wr[%0d]", k), 32'(mem_wr), 1);
      chk($sformatf("t2.data[%0d]", k), mem_data_in,
          (k % 2 == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1);
      chk($sformatf("t2.owner[%0d]", k), 32'(last_owner), 32'(k % 2));
      tick(); tick(); tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // 3: req1 write, corrected error in first IDLE cycle.
    req1_valid = 1'b1; req1_data = 32'h00001234;
    #1;
    chk("t3.ready1", 32'(req1_ready), 1);
    tick(); req1_valid = 1'b0;
    tick(); tick(); tick();
    chk("t3.idle", 32'(busy), 0);
    mem_err_detected = 1'b1; mem_err_corrected = 1'b1;
    tick();
    chk_cnt("t3", 1, 0, 1, 0);
    tick(); tick();
    chk("t3.persist", 32'(err_cnt_det), 1);
    mem_err_detected = 1'b0; mem_err_corrected = 1'b0;
    tick();

    // 4: two uncorrected events reach threshold 2, then clear.
    mem_err_detected = 1'b1;
    tick();
    chk_cnt("t4.ev1", 2, 1, 1, 0);
    mem_err_detected = 1'b0; tick();
    mem_err_detected = 1'b1; tick();
    chk_cnt("t4.ev2", 3, 2, 1, 1);
    mem_err_detected = 1'b0; tick();
    mem_err_detected = 1'b1; err_clr = 1'b1;
    tick();
    chk_cnt("t4.clr", 0, 0, 1, 0);
    err_clr = 1'b0;
    tick();
    chk("t4.dropped", 32'(err_cnt_det), 0);
    mem_err_detected = 1'b0; tick();

    // 5: pulse only during SETTLE is ignored; then saturation at 3.
    req0_valid = 1'b1; req0_data = 32'h55;
    #1;
    chk("t5.ready0", 32'(req0_ready), 1);
    tick(); req0_valid = 1'b0;
    tick(); mem_err_detected = 1'b1;
    tick(); mem_err_detected = 1'b0;
    tick();
    chk("t5.idle", 32'(busy), 0);
    tick();
    chk("t5.masked", 32'(err_cnt_det), 0);
    chk("t5.last_owner", 32'(last_owner), 0);
    for (int k = 0; k < 5; k++) begin
      mem_err_detected = 1'b1; tick();
      mem_err_detected = 1'b0; tick();
    end
    chk_cnt("t5.sat", 3, 3, 0, 1);

    // 6: reset during the mem_wr cycle.
    req1_valid = 1'b1; req1_data = 32'h0000BEEF;
    #1;
    chk("t6.ready1", 32'(req1_ready), 1);
    tick(); req1_valid = 1'b0;
    chk("t6.mem_wr", 32'(mem_wr), 1);
    rst = 1'b1;
    tick();
    chk("t6.mem_wr_rst", 32'(mem_wr), 0);
    chk("t6.busy_rst", 32'(busy), 0);
    chk("t6.data_rst", mem_data_in, 0);
    chk_cnt("t6.rst", 0, 0, 0, 0);
    rst = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h0000C0DE;
    req1_valid = 1'b1; req1_data = 32'h0000FACE;
    #1;
    chk("t6.ready0", 32'(req0_ready), 1);
    chk("t6.ready1", 32'(req1_ready), 0);
    tick();
    chk("t6.data", mem_data_in, 32'h0000C0DE);
    chk("t6.owner", 32'(last_owner), 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
